// File: rtl/cpu_debug_port.sv
// Host-side debug port for the CPU: owns cpu_tick generation, halting, single-step and
// control-word injection with a break-before-make ctrlen/cw_oe handover.
module cpu_debug_port #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CW_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CW_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [7:0]          rsp_data,
  output logic                halted,
  input  logic                brk,
  input  logic [7:0]          main_bus,
  output logic                cpu_tick,
  output logic                ctrlen,
  output logic [CW_WIDTH-1:0] cw_out,
  output logic                cw_oe
);

  typedef enum logic [2:0] {
    StHalted, StRun, StStepT, StInjSetup, StInjDrive, StInjTick, StInjHold, StInjRel
  } state_e;

  localparam logic [1:0] OpRun    = 2'd0;
  localparam logic [1:0] OpHalt   = 2'd1;
  localparam logic [1:0] OpStep   = 2'd2;
  localparam logic [1:0] OpInject = 2'd3;
  localparam logic [7:0] DivLast  = 8'(TICK_DIV - 1);

  state_e                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [7:0]            cap_q, cap_d;
  logic [CW_WIDTH-1:0]   word_q, word_d;
  logic [7:0]            rsp_data_d;
  logic                  rsp_valid_d, tick_d, accept;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cap_d       = cap_q;
    word_d      = word_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    tick_d      = 1'b0;
    unique case (state_q)
      StHalted: begin
        if (accept) begin
          unique case (cmd_op)
            OpRun: begin
              state_d     = StRun;
              div_d       = 8'd0;
              rsp_valid_d = 1'b1;
              rsp_data_d  = 8'h00;
            end
            OpHalt: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = 8'h00;
            end
            OpStep: begin
              state_d = StStepT;
              tick_d  = 1'b1;
            end
            OpInject: begin
              state_d = StInjSetup;
              word_d  = cmd_data;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        div_d  = (div_q == DivLast) ? 8'd0 : div_q + 8'd1;
        tick_d = (div_q == DivLast);
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = (cmd_op == OpStep || cmd_op == OpInject) ? 8'hFF : 8'h00;
          if (cmd_op == OpHalt) begin
            state_d = StHalted;
            div_d   = 8'd0;
            tick_d  = 1'b0;
          end
        end
        // A breakpoint raised while a tick is in flight is ignored until the next sample.
        if (brk && !cpu_tick) begin
          state_d = StHalted;
          div_d   = 8'd0;
          tick_d  = 1'b0;
        end
      end
      StStepT: begin
        state_d     = StHalted;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 8'h00;
      end
      StInjSetup: state_d = StInjDrive;
      StInjDrive: begin
        state_d = StInjTick;
        tick_d  = 1'b1;
      end
      StInjTick: begin
        state_d = StInjHold;
        cap_d   = main_bus;
      end
      StInjHold: state_d = StInjRel;
      StInjRel: begin
        state_d     = StHalted;
        rsp_valid_d = 1'b1;
        rsp_data_d  = cap_q;
      end
      default: state_d = StHalted;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StHalted;
      div_q     <= 8'd0;
      cap_q     <= 8'd0;
      word_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      cpu_tick  <= 1'b0;
      halted    <= 1'b1;
      cmd_ready <= 1'b1;
      ctrlen    <= 1'b1;
      cw_oe     <= 1'b0;
      cw_out    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cap_q     <= cap_d;
      word_q    <= word_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      cpu_tick  <= tick_d;
      halted    <= (state_d != StRun);
      cmd_ready <= (state_d inside {StHalted, StRun});
      ctrlen    <= !(state_d inside {StInjSetup, StInjDrive, StInjTick, StInjHold, StInjRel});
      cw_oe     <= (state_d inside {StInjDrive, StInjTick, StInjHold});
      cw_out    <= (state_d inside {StInjDrive, StInjTick, StInjHold}) ? word_d : '0;
    end
  end

endmodule

// File: tb/tb_cpu_debug_port.sv
// Directed and randomized bench for cpu_debug_port against a latency/response model.
module tb_cpu_debug_port;

  localparam int unsigned TD = 4;
  localparam int unsigned CWW = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [CWW-1:0]  cmd_data;
  logic            rsp_valid;
  logic [7:0]      rsp_data;
  logic            halted;
  logic            brk;
  logic [7:0]      main_bus;
  logic            cpu_tick;
  logic            ctrlen;
  logic [CWW-1:0]  cw_out;
  logic            cw_oe;

  int n_assert = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int rsp_cnt  = 0;

  cpu_debug_port #(.TICK_DIV(TD), .CW_WIDTH(CWW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .halted    (halted),
    .brk       (brk),
    .main_bus  (main_bus),
    .cpu_tick  (cpu_tick),
    .ctrlen    (ctrlen),
    .cw_out    (cw_out),
    .cw_oe     (cw_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event counters and the never-both-drivers invariant, sampled just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cpu_tick === 1'b1) tick_cnt++;
      if (rsp_valid === 1'b1) rsp_cnt++;
      check("drivers_exclusive", {31'd0, cw_oe & ctrlen}, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called right after a negedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] op, input logic [31:0] data);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", {31'd0, w < 20}, 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
  endtask

  // Reference model from HALTED: edges after acceptance until rsp, data, ticks issued.
  function automatic void model(input logic [1:0] op, input logic [7:0] bus, output int lat,
                                output logic [7:0] data, output int ticks);
    case (op)
      2'd2:    begin lat = 1; data = 8'h00; ticks = 1; end
      2'd3:    begin lat = 5; data = bus;   ticks = 1; end
      default: begin lat = 0; data = 8'h00; ticks = 0; end
    endcase
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] data, input logic [7:0] bus,
                        input string tag);
    int lat = -1;
    int t0;
    int elat;
    int eticks;
    logic [7:0] got = 8'h00;
    logic [7:0] edata;
    model(op, bus, elat, edata, eticks);
    main_bus = bus;
    t0 = tick_cnt;
    send(op, data);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && lat < 0) begin
        lat = k;
        got = rsp_data;
      end
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_data"}, {24'd0, got}, {24'd0, edata});
    check({tag, "_ticks"}, tick_cnt - t0, eticks);
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  // Cycle-by-cycle inject check; bus is only valid during the tick cycle.
  task automatic inject_seq(input logic [31:0] word, input logic [7:0] bus, input string tag);
    logic [7:0] other;
    bit oe;
    other = ~bus;
    main_bus = other;
    send(2'd3, word);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      oe = (k >= 1 && k <= 3);
      check({tag, "_ctrlen"}, {31'd0, ctrlen}, {31'd0, k > 4});
      check({tag, "_cw_oe"}, {31'd0, cw_oe}, {31'd0, oe});
      check({tag, "_cw_out"}, cw_out, oe ? word : 32'd0);
      check({tag, "_tick"}, {31'd0, cpu_tick}, {31'd0, k == 2});
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, {31'd0, k == 5});
      if (k == 5) check({tag, "_rsp_data"}, {24'd0, rsp_data}, {24'd0, bus});
      if (k == 2) main_bus = bus;
      if (k == 3) main_bus = other;
    end
  endtask

  initial begin
    int r0;
    int t0;
    logic [1:0] op;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = '0;
    brk = 1'b0;
    main_bus = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_ctrlen", {31'd0, ctrlen}, 32'd1);
    check("rst_cw_oe", {31'd0, cw_oe}, 32'd0);
    check("rst_cw_out", cw_out, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_cpu_tick", {31'd0, cpu_tick}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // RUN: response next cycle, ticks every TD cycles after acceptance.
    send(2'd0, 32'd0);
    @(negedge clk);
    check("run_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("run_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("run_halted", {31'd0, halted}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("run_tick_%0d", k), {31'd0, cpu_tick}, {31'd0, (k % TD) == 0});
    end

    // Breakpoint between ticks halts silently.
    @(negedge clk);
    @(negedge clk);
    r0 = rsp_cnt;
    t0 = tick_cnt;
    brk = 1'b1;
    @(negedge clk);
    brk = 1'b0;
    check("brk_halted", {31'd0, halted}, 32'd1);
    repeat (8) @(negedge clk);
    check("brk_no_ticks", tick_cnt - t0, 32'd0);
    check("brk_no_rsp", rsp_cnt - r0, 32'd0);
    check("brk_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Three single steps.
    t0 = tick_cnt;
    r0 = rsp_cnt;
    for (int i = 0; i < 3; i++) do_cmd(2'd2, 32'd0, 8'h00, $sformatf("step%0d", i));
    check("step_total_ticks", tick_cnt - t0, 32'd3);
    check("step_total_rsp", rsp_cnt - r0, 32'd3);

    // Directed inject, then randomized injects.
    inject_seq(32'h0012_3400, 8'hA5, "inj");
    for (int i = 0; i < 4; i++) inject_seq($urandom, 8'($urandom), $sformatf("rinj%0d", i));

    // Randomized command mix from HALTED against the model.
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(1, 3));
      do_cmd(op, $urandom, 8'($urandom), $sformatf("rnd%0d_op%0d", i, op));
    end

    // INJECT and STEP while running are rejected without disturbing the run.
    send(2'd0, 32'd0);
    @(negedge clk);
    check("run2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    send(2'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rej_inj_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rej_inj_rsp_data", {24'd0, rsp_data}, 32'hFF);
    check("rej_inj_ctrlen", {31'd0, ctrlen}, 32'd1);
    check("rej_inj_halted", {31'd0, halted}, 32'd0);
    send(2'd2, 32'd0);
    @(negedge clk);
    check("rej_step_rsp_data", {24'd0, rsp_data}, 32'hFF);
    check("rej_step_halted", {31'd0, halted}, 32'd0);
    t0 = tick_cnt;
    repeat (2 * TD) @(negedge clk);
    check("run_continues_ticks", tick_cnt - t0, 32'd2);

    // HALT coincident with brk: exactly one response.
    r0 = rsp_cnt;
    brk = 1'b1;
    send(2'd1, 32'd0);
    brk = 1'b0;
    repeat (4) @(negedge clk);
    check("halt_brk_rsp_count", rsp_cnt - r0, 32'd1);
    check("halt_brk_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("halt_brk_halted", {31'd0, halted}, 32'd1);

    // Reset during INJ_DRIVE aborts with no response.
    send(2'd3, 32'h5555_AAAA);
    @(negedge clk);
    check("abort_setup_ctrlen", {31'd0, ctrlen}, 32'd0);
    @(negedge clk);
    check("abort_drive_cw_oe", {31'd0, cw_oe}, 32'd1);
    r0 = rsp_cnt;
    rstn = 1'b0;
    @(negedge clk);
    check("abort_ctrlen", {31'd0, ctrlen}, 32'd1);
    check("abort_cw_oe", {31'd0, cw_oe}, 32'd0);
    check("abort_halted", {31'd0, halted}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - r0, 32'd0);
    do_cmd(2'd2, 32'd0, 8'h00, "post_reset_step");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
